gear_err_monitor: RTL and testbench

GEAR_ERR_MONITOR -- requirements
Module: gear_err_monitor

---
 rtl/gear_err_monitor_if.sv | 22 ++
 rtl/gear_err_monitor.sv | 100 ++++++++++
 tb/tb_gear_err_monitor.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/gear_err_monitor_if.sv
// gear_err_monitor_if: sample stream and statistics bundle between the monitor and its environment.
interface gear_err_monitor_if;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [8:0]  approx_sum;
  logic        busy;
  logic        done;
  logic [8:0]  err_count;
  logic [16:0] sed;
  logic [8:0]  max_ed;
  modport master (
    output start, in_valid, a, b, approx_sum,
    input  in_ready, busy, done, err_count, sed, max_ed
  );
  modport slave (
    input  start, in_valid, a, b, approx_sum,
    output in_ready, busy, done, err_count, sed, max_ed
  );
endinterface

// File: rtl/gear_err_monitor.sv
// gear_err_monitor: windowed error statistics (count, sum, max distance) for an 8-bit GeAr adder.
// max_ed tracking is built only when GEAR_MON_MAXED_EN is defined; otherwise max_ed reads 0.
module gear_err_monitor #(
  parameter int N_SAMPLES = 256
) (
  input logic             clk,
  input logic             rst_n,
  gear_err_monitor_if.slave io_bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t            r_state;
  logic [8:0]        r_cnt;
  logic [8:0]        r_ed;
  logic [8:0]        r_err;
  logic [16:0]       r_sed;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_drain;
  logic              r_v1;
  logic              w_accept;
  logic              w_clear;
  logic [8:0]        w_exact;
  logic [8:0]        w_ed;
  logic signed [9:0] w_diff;
  assign w_accept = io_bus.in_valid && r_in_ready;
  assign w_clear  = (r_state == IDLE) && io_bus.start;
  assign w_exact  = {1'b0, io_bus.a} + {1'b0, io_bus.b};
  assign w_diff   = $signed({1'b0, w_exact}) - $signed({1'b0, io_bus.approx_sum});
  assign w_ed     = w_diff[9] ? 9'(-w_diff) : w_diff[8:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ed       <= '0;
      r_err      <= '0;
      r_sed      <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_drain    <= 1'b0;
      r_v1       <= 1'b0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) r_ed <= w_ed;
      if (r_v1 && r_ed != '0) begin
        r_err <= r_err + 9'd1;
        r_sed <= r_sed + 17'(r_ed);
      end
      case (r_state)
        IDLE: if (io_bus.start) begin
          r_state    <= RUN;
          r_cnt      <= '0;
          r_err      <= '0;
          r_sed      <= '0;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b1;
        end
        RUN: if (w_accept) begin
          r_cnt <= r_cnt + 9'd1;
          if (r_cnt == 9'(N_SAMPLES - 1)) begin
            r_state    <= DRAIN;
            r_in_ready <= 1'b0;
            r_drain    <= 1'b0;
          end
        end
        DRAIN: begin
          r_drain <= 1'b1;
          if (r_drain) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end
`ifdef GEAR_MON_MAXED_EN
  logic [8:0] r_max_ed;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_max_ed <= '0;
    else if (w_clear) r_max_ed <= '0;
    else if (r_v1 && r_ed > r_max_ed) r_max_ed <= r_ed;
  end
  assign io_bus.max_ed = r_max_ed;
`else
  logic w_unused;
  assign w_unused      = w_clear;
  assign io_bus.max_ed = '0;
`endif
  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.busy      = r_busy;
  assign io_bus.done      = r_done;
  assign io_bus.err_count = r_err;
  assign io_bus.sed       = r_sed;
endmodule

// File: tb/tb_gear_err_monitor.sv
// tb_gear_err_monitor: directed checks of window statistics, timing, reset and ignored start/valid.
module tb_gear_err_monitor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int d4 = 0;
  int d256 = 0;
`ifdef GEAR_MON_MAXED_EN
  localparam logic [8:0] MAX_EXP = 9'd30;
`else
  localparam logic [8:0] MAX_EXP = 9'd0;
`endif
  // eds of the four-sample stream: 30, 0, 14 (510-496), 2 (68-66)
  localparam logic [8:0]  ERR_EXP = 9'd3;
  localparam logic [16:0] SED_EXP = 17'd46;
  logic [7:0] va [4] = '{8'h0F, 8'h12, 8'hFF, 8'h33};
  logic [7:0] vb [4] = '{8'h0F, 8'h21, 8'hFF, 8'h11};
  logic [8:0] vs [4] = '{9'h000, 9'h033, 9'h1F0, 9'h042};
  always #5 clk = ~clk;
  gear_err_monitor_if m4();
  gear_err_monitor_if m256();
  gear_err_monitor #(.N_SAMPLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .io_bus(m4.slave));
  gear_err_monitor #(.N_SAMPLES(256)) dut256 (.clk(clk), .rst_n(rst_n), .io_bus(m256.slave));
  always @(posedge clk) begin
    if (m4.done === 1'b1) d4++;
    if (m256.done === 1'b1) d256++;
  end
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({m4.in_ready, m4.busy, m4.done, m4.err_count, m4.sed, m4.max_ed} !== '0) begin
      errors++;
      $display("FAIL reset4 got rdy=%b busy=%b done=%b err=%0d sed=%0d max=%0d want all 0",
               m4.in_ready, m4.busy, m4.done, m4.err_count, m4.sed, m4.max_ed);
    end
    checks++;
    if ({m256.in_ready, m256.busy, m256.done, m256.err_count, m256.sed} !== '0) begin
      errors++;
      $display("FAIL reset256 got rdy=%b busy=%b done=%b err=%0d sed=%0d want all 0",
               m256.in_ready, m256.busy, m256.done, m256.err_count, m256.sed);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic run_stream4(input bit gapped, input bit poke, input string tag);
    int lat;
    d4 = 0;
    m4.start = 1'b1;
    @(negedge clk);
    m4.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (gapped && i == 2) begin
        m4.in_valid = 1'b0;
        repeat (3) begin
          checks++;
          if (m4.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s gap_ready got %b want 1", tag, m4.in_ready);
          end
          @(negedge clk);
        end
      end
      m4.a = va[i]; m4.b = vb[i]; m4.approx_sum = vs[i];
      m4.in_valid = 1'b1;
      m4.start = poke && i == 1;
      checks++;
      if (m4.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s ready_s%0d got %b want 1", tag, i, m4.in_ready);
      end
      @(negedge clk);
    end
    // an extra high-error sample that must not be taken
    m4.start = poke; m4.in_valid = poke;
    m4.a = 8'h00; m4.b = 8'h80; m4.approx_sum = 9'h000;
    checks++;
    if (m4.in_ready !== 1'b0 || m4.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s drain_flags got rdy=%b busy=%b want rdy=0 busy=1", tag, m4.in_ready, m4.busy);
    end
    lat = 0;
    while (m4.done !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    m4.start = 1'b0; m4.in_valid = 1'b0;
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL %s done_latency got %0d want 2", tag, lat);
    end
    checks++;
    if (m4.err_count !== ERR_EXP || m4.sed !== SED_EXP || m4.max_ed !== MAX_EXP) begin
      errors++;
      $display("FAIL %s stats got err=%0d sed=%0d max=%0d want err=%0d sed=%0d max=%0d",
               tag, m4.err_count, m4.sed, m4.max_ed, ERR_EXP, SED_EXP, MAX_EXP);
    end
    @(negedge clk);
    checks++;
    if (m4.done !== 1'b0 || m4.busy !== 1'b0 || d4 !== 1) begin
      errors++;
      $display("FAIL %s done_pulse got done=%b busy=%b pulses=%0d want 0 0 1", tag, m4.done, m4.busy, d4);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (m4.err_count !== ERR_EXP || m4.sed !== SED_EXP || m4.max_ed !== MAX_EXP) begin
      errors++;
      $display("FAIL %s held got err=%0d sed=%0d max=%0d want err=%0d sed=%0d max=%0d",
               tag, m4.err_count, m4.sed, m4.max_ed, ERR_EXP, SED_EXP, MAX_EXP);
    end
  endtask
  task automatic test_basic();
    run_stream4(1'b0, 1'b0, "basic");
  endtask
  task automatic test_gapped();
    run_stream4(1'b1, 1'b0, "gapped");
  endtask
  task automatic test_ignore_start();
    run_stream4(1'b0, 1'b1, "ignore");
  endtask
  task automatic test_reset_mid();
    m4.start = 1'b1;
    @(negedge clk);
    m4.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m4.a = va[i]; m4.b = vb[i]; m4.approx_sum = vs[i];
      m4.in_valid = 1'b1;
      @(negedge clk);
    end
    m4.in_valid = 1'b0;
    checks++;
    if (m4.sed !== 17'd30 || m4.err_count !== 9'd1) begin
      errors++;
      $display("FAIL midrun got err=%0d sed=%0d want err=1 sed=30", m4.err_count, m4.sed);
    end
    d4 = 0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m4.in_ready, m4.busy, m4.done, m4.err_count, m4.sed, m4.max_ed} !== '0) begin
      errors++;
      $display("FAIL async_reset got rdy=%b busy=%b done=%b err=%0d sed=%0d max=%0d want all 0",
               m4.in_ready, m4.busy, m4.done, m4.err_count, m4.sed, m4.max_ed);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (d4 !== 0 || m4.busy !== 1'b0) begin
      errors++;
      $display("FAIL no_done_after_reset got pulses=%0d busy=%b want 0 0", d4, m4.busy);
    end
    run_stream4(1'b0, 1'b0, "restart");
  endtask
  task automatic test_back_to_back();
    int lat;
    int bad_ready;
    bad_ready = 0;
    d256 = 0;
    m256.start = 1'b1;
    @(negedge clk);
    m256.start = 1'b0;
    m256.a = 8'h0F; m256.b = 8'h0F; m256.approx_sum = 9'h000;
    m256.in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if (m256.in_ready !== 1'b1) bad_ready++;
      @(negedge clk);
    end
    m256.in_valid = 1'b0;
    checks++;
    if (bad_ready !== 0 || m256.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready got low_in_run=%0d rdy_after=%b want 0 0", bad_ready, m256.in_ready);
    end
    lat = 0;
    while (m256.done !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        checks++;
        if (m256.sed !== 17'd7680 || m256.busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_final_drain got sed=%0d busy=%b want 7680 1", m256.sed, m256.busy);
        end
      end
    end
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL b2b_done_latency got %0d want 2", lat);
    end
    checks++;
    if (m256.err_count !== 9'd256 || m256.sed !== 17'd7680 || m256.max_ed !== MAX_EXP) begin
      errors++;
      $display("FAIL b2b_stats got err=%0d sed=%0d max=%0d want err=256 sed=7680 max=%0d",
               m256.err_count, m256.sed, m256.max_ed, MAX_EXP);
    end
    @(negedge clk);
    checks++;
    if (d256 !== 1 || m256.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_pulse got pulses=%0d done=%b want 1 0", d256, m256.done);
    end
  endtask
  initial begin
    m4.start = 1'b0; m4.in_valid = 1'b0; m4.a = '0; m4.b = '0; m4.approx_sum = '0;
    m256.start = 1'b0; m256.in_valid = 1'b0; m256.a = '0; m256.b = '0; m256.approx_sum = '0;
    test_reset();
    test_basic();
    test_gapped();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
